sp_ram_be: RTL and testbench

// Parametrised single-port synchronous RAM; next generation of the fixed 32-bit x 1024 sp_ram.

---
 rtl/sp_ram_be.sv | 129 ++++++++++++
 tb/tb_sp_ram_be.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_be.sv
// sp_ram_be: parametrised single-port synchronous RAM with byte write enables,
// selectable read-during-write behaviour, optional output register and a
// reset-triggered clear engine that fills every word with CLR_VAL.
module sp_ram_be #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       RDW_MODE = 0,
    parameter int unsigned       OUT_REG  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data,
    output logic [DATA_W-1:0]     q,
    output logic                  q_valid,
    output logic                  ready
);

    localparam int unsigned       BE_W     = DATA_W / 8;
    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    // Parameter sanity checks at elaboration
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("sp_ram_be: DATA_W must be a multiple of 8");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw_mode
        $error("sp_ram_be: RDW_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   old_word;
    logic [DATA_W-1:0]   merged;
    logic                acc;
    logic [DATA_W-1:0]   r1;
    logic                v1;

    // Accesses are only taken once the clear has finished
    assign acc = en && ready;

    // Current word at addr and the byte-merged write result
    always_comb begin
        old_word = mem[addr];
        merged   = old_word;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    // Clear/run FSM; the last clear write hands over to RUN and raises ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
            if (clr_ptr == LAST_PTR) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    // Single memory write port shared by the clear engine and user writes
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= CLR_VAL;
            end else if (acc && we) begin
                mem[addr] <= merged;
            end
        end
    end

    // Stage-1 read register; write behaviour follows RDW_MODE
    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= 1'b0;
            if (acc) begin
                if (!we) begin
                    r1 <= old_word;
                    v1 <= 1'b1;
                end else if (RDW_MODE == 0) begin
                    r1 <= merged;
                    v1 <= 1'b1;
                end else if (RDW_MODE == 1) begin
                    r1 <= old_word;
                    v1 <= 1'b1;
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        // Output register; q keeps its last value until new valid data arrives
        always_ff @(posedge clk) begin
            if (rst) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else begin
                q_valid <= v1;
                if (v1) begin
                    q <= r1;
                end
            end
        end
    end else begin : g_no_out_reg
        assign q       = r1;
        assign q_valid = v1;
    end

endmodule

// File: tb/tb_sp_ram_be.sv
// tb_sp_ram_be: six DUT instances (every RDW_MODE x OUT_REG pairing) share one
// stimulus stream; directed vector table plus a cycle model checked every clock.
`timescale 1ns/1ps
module tb_sp_ram_be;

    localparam int          NI  = 6;
    localparam logic [31:0] CLR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst, en, we;
    logic [3:0]  be, addr;
    logic [31:0] data;
    logic [31:0] dq [NI];
    logic        dv [NI];
    logic        dr [NI];

    always #5 clk = ~clk;

    // Instance g: RDW_MODE = g % 3, OUT_REG = g / 3
    for (genvar g = 0; g < NI; g++) begin : g_dut
        sp_ram_be #(
            .DATA_W  (32),
            .ADDR_W  (4),
            .RDW_MODE(g % 3),
            .OUT_REG (g / 3),
            .CLR_VAL (CLR)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .we     (we),
            .be     (be),
            .addr   (addr),
            .data   (data),
            .q      (dq[g]),
            .q_valid(dv[g]),
            .ready  (dr[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [31:0] mm   [16];
    logic        m_rdy;
    logic [3:0]  m_ptr;
    logic [31:0] m_r1 [NI];
    logic        m_v1 [NI];
    logic [31:0] m_q  [NI];
    logic        m_qv [NI];

    typedef struct {
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] eq0;
        logic [31:0] eq1;
        logic [31:0] eq2;
        logic [2:0]  ev;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] sb  [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick_q(input vec_t r, input int m);
        return (m == 0) ? r.eq0 : (m == 1) ? r.eq1 : r.eq2;
    endfunction

    // One clock: advance the model on the inputs seen at the edge, then compare
    task automatic tick();
        logic        c_rst, c_en, c_we, acc, pv1;
        logic [3:0]  c_be, c_addr;
        logic [31:0] c_data, old, mrg, pr1;
        c_rst = rst; c_en = en; c_we = we; c_be = be; c_addr = addr; c_data = data;
        @(posedge clk);
        #1;
        if (c_rst) begin
            m_rdy = 1'b0;
            m_ptr = 4'd0;
            for (int i = 0; i < NI; i++) begin
                m_r1[i] = 32'd0; m_v1[i] = 1'b0; m_q[i] = 32'd0; m_qv[i] = 1'b0;
            end
        end else begin
            acc = m_rdy && c_en;
            old = mm[c_addr];
            mrg = old;
            for (int b = 0; b < 4; b++) if (c_be[b]) mrg[8*b +: 8] = c_data[8*b +: 8];
            for (int i = 0; i < NI; i++) begin
                pr1 = m_r1[i];
                pv1 = m_v1[i];
                m_v1[i] = 1'b0;
                if (acc) begin
                    if (!c_we)            begin m_r1[i] = old; m_v1[i] = 1'b1; end
                    else if (i % 3 == 0)  begin m_r1[i] = mrg; m_v1[i] = 1'b1; end
                    else if (i % 3 == 1)  begin m_r1[i] = old; m_v1[i] = 1'b1; end
                end
                if (i >= 3) begin
                    if (pv1) m_q[i] = pr1;
                    m_qv[i] = pv1;
                end else begin
                    m_q[i]  = m_r1[i];
                    m_qv[i] = m_v1[i];
                end
            end
            if (!m_rdy) begin
                mm[m_ptr] = CLR;
                if (m_ptr == 4'hF) m_rdy = 1'b1;
                m_ptr = m_ptr + 4'd1;
            end else if (acc && c_we) begin
                mm[c_addr] = mrg;
            end
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("model q[%0d]", i), dq[i], m_q[i]);
            chk($sformatf("model q_valid[%0d]", i), 32'(dv[i]), 32'(m_qv[i]));
            chk($sformatf("model ready[%0d]", i), 32'(dr[i]), 32'(m_rdy));
        end
    endtask

    // Counts clocks from rst low until ready; must be exactly 16, never q_valid meanwhile
    task automatic wait_ready(input string name);
        int   n;
        logic seen_v;
        n = 0;
        seen_v = 1'b0;
        while (!dr[0] && n < 40) begin
            tick();
            n++;
            for (int i = 0; i < NI; i++) seen_v = seen_v | dv[i];
        end
        chk({name, " clear length"}, 32'(n), 32'd16);
        chk({name, " q_valid during clear"}, 32'(seen_v), 32'd0);
    endtask

    task automatic chk_reset_state(input string name);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s q[%0d]", name, i), dq[i], 32'd0);
            chk($sformatf("%s q_valid[%0d]", name, i), 32'(dv[i]), 32'd0);
            chk($sformatf("%s ready[%0d]", name, i), 32'(dr[i]), 32'd0);
        end
    endtask

    task automatic readback_clr(input string name);
        for (int a = 0; a < 16; a++) begin
            en = 1'b1; we = 1'b0; addr = 4'(a);
            tick();
            chk($sformatf("%s rd %0d", name, a), dq[0], CLR);
            chk($sformatf("%s rd %0d valid", name, a), 32'(dv[0]), 32'd1);
        end
        en = 1'b0;
        tick();
        chk({name, " outreg q"}, dq[3], CLR);
        chk({name, " outreg valid"}, 32'(dv[3]), 32'd1);
        tick();
    endtask

    initial begin
        logic [31:0] pq [3];
        logic [2:0]  pv;
        logic [31:0] d;

        rst = 1'b1; en = 1'b0; we = 1'b0; be = 4'h0; addr = 4'h0; data = 32'h0;
        tick();
        tick();
        chk_reset_state("reset");

        // Clear after reset, with reads requested throughout
        rst = 1'b0; en = 1'b1; we = 1'b0; addr = 4'd3;
        wait_ready("initial");
        en = 1'b0;
        readback_clr("clear");

        // Directed vectors: expected q per RDW mode for OUT_REG=0; OUT_REG=1 lags one row
        tbl.push_back('{1'b1, 1'b1, 4'hF, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b011});
        tbl.push_back('{1'b1, 1'b1, 4'h5, 4'd3, 32'h12345678, 32'hFF34FF78, 32'hFFFFFFFF, 32'hDEADBEEF, 3'b011});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd3, 32'h00000000, 32'hFF34FF78, 32'hFF34FF78, 32'hFF34FF78, 3'b111});
        tbl.push_back('{1'b1, 1'b1, 4'hF, 4'd5, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hDEADBEEF, 32'hFF34FF78, 3'b011});
        tbl.push_back('{1'b1, 1'b1, 4'hF, 4'd5, 32'h55555555, 32'h55555555, 32'hAAAAAAAA, 32'hFF34FF78, 3'b011});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd5, 32'h00000000, 32'h55555555, 32'h55555555, 32'h55555555, 3'b111});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 4'd0, 32'h00000000, 32'h55555555, 32'h55555555, 32'h55555555, 3'b000});
        tbl.push_back('{1'b1, 1'b1, 4'h0, 4'd7, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, 32'h55555555, 3'b011});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd7, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b111});
        tbl.push_back('{1'b1, 1'b1, 4'h8, 4'd0, 32'hCAFEF00D, 32'hCAADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 3'b011});
        tbl.push_back('{1'b1, 1'b0, 4'h0, 4'd0, 32'h00000000, 32'hCAADBEEF, 32'hCAADBEEF, 32'hCAADBEEF, 3'b111});

        pq = '{CLR, CLR, CLR};
        pv = 3'b000;
        foreach (tbl[r]) begin
            en = tbl[r].en; we = tbl[r].we; be = tbl[r].be; addr = tbl[r].addr; data = tbl[r].data;
            tick();
            for (int m = 0; m < 3; m++) begin
                chk($sformatf("vec %0d mode %0d q", r, m), dq[m], pick_q(tbl[r], m));
                chk($sformatf("vec %0d mode %0d valid", r, m), 32'(dv[m]), 32'(tbl[r].ev[m]));
                chk($sformatf("vec %0d mode %0d outreg q", r, m), dq[m+3], pq[m]);
                chk($sformatf("vec %0d mode %0d outreg valid", r, m), 32'(dv[m+3]), 32'(pv[m]));
                pq[m] = pick_q(tbl[r], m);
            end
            pv = tbl[r].ev;
        end
        en = 1'b0;
        tick();

        // Same-address write then read on consecutive cycles, read-first instance
        en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'd9; data = 32'h0BADC0DE;
        tick();
        we = 1'b0;
        tick();
        chk("wr->rd same addr read-first", dq[1], 32'h0BADC0DE);
        en = 1'b0;
        tick();

        // Basic: 32 full-word writes, then isolated reads to show both latencies
        for (int k = 0; k < 32; k++) begin
            d = $urandom;
            en = 1'b1; we = 1'b1; be = 4'hF; addr = 4'(k % 16); data = d;
            sb[k % 16] = d;
            tick();
        end
        en = 1'b0;
        tick();
        for (int a = 0; a < 16; a++) begin
            en = 1'b1; we = 1'b0; addr = 4'(a);
            tick();
            chk($sformatf("basic rd %0d lat1 q", a), dq[0], sb[a]);
            chk($sformatf("basic rd %0d lat1 valid", a), 32'(dv[0]), 32'd1);
            chk($sformatf("basic rd %0d lat2 early valid", a), 32'(dv[3]), 32'd0);
            en = 1'b0;
            tick();
            chk($sformatf("basic rd %0d lat2 q", a), dq[3], sb[a]);
            chk($sformatf("basic rd %0d lat2 valid", a), 32'(dv[3]), 32'd1);
            chk($sformatf("basic rd %0d lat1 drop", a), 32'(dv[0]), 32'd0);
        end

        // Reset in the middle of a clear restarts it from zero
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1'b1;
        tick();
        chk_reset_state("rst mid-clear");
        rst = 1'b0;
        wait_ready("mid-clear");

        // Reset during back-to-back reads drops them and reruns the clear
        for (int k = 0; k < 4; k++) begin
            en = 1'b1; we = 1'b0; addr = 4'(k + 2);
            tick();
        end
        rst = 1'b1;
        tick();
        chk_reset_state("rst mid-read");
        rst = 1'b0;
        wait_ready("mid-read");
        en = 1'b0;
        readback_clr("reclear");

        // Random stress with rare resets; addresses biased to force same-addr hazards
        for (int k = 0; k < 10000; k++) begin
            rst  = ($urandom_range(0, 999) == 0);
            en   = ($urandom_range(0, 3) != 0);
            we   = 1'($urandom_range(0, 1));
            be   = 4'($urandom);
            addr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 1)) : 4'($urandom);
            data = $urandom;
            tick();
        end
        rst = 1'b0; en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
